// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-to-1 valid/ready mux with round-robin arbitration and a registered, channel-tagged output.
// Define RR_MUX_FIXED_PRIO_EN for fixed lowest-index-first priority; the round-robin pointer is then dropped.
module rr_stream_mux #(
  parameter int N_CH = 4,
  parameter int DATA_W = 8,
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH-1:0]          in_valid,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  output logic [N_CH-1:0]          in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  input  logic                     out_ready
);
  logic              load_en, found;
  logic [SEL_W-1:0]  ptr, off, win;
  logic [SEL_W:0]    wsum;
  logic [N_CH-1:0]   rot;
  logic [DATA_W-1:0] win_data;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [SEL_W-1:0]  out_sel_q;
  assign load_en = !out_valid_q || out_ready;
  // Rotate so bit 0 is the channel at ptr; the lowest set bit is then the round-robin winner.
  assign rot = N_CH'({in_valid, in_valid} >> ptr);
  always_comb begin
    found = 1'b0;
    off = '0;
    for (int k = N_CH - 1; k >= 0; k--)
      if (rot[k]) begin
        found = 1'b1;
        off = SEL_W'(k);
      end
  end
  assign wsum = {1'b0, ptr} + {1'b0, off};
  assign win = (wsum >= (SEL_W+1)'(N_CH)) ? SEL_W'(wsum - (SEL_W+1)'(N_CH)) : wsum[SEL_W-1:0];
  assign in_ready = (rst_n && load_en && found) ? (N_CH'(1) << win) : '0;
  always_comb begin
    win_data = '0;
    for (int k = 0; k < N_CH; k++)
      if (SEL_W'(k) == win) win_data = in_data[k*DATA_W +: DATA_W];
  end
`ifdef RR_MUX_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [SEL_W-1:0] ptr_q, ptr_d;
  assign ptr = ptr_q;
  assign ptr_d = (load_en && found) ? ((win == SEL_W'(N_CH - 1)) ? '0 : win + 1'b1) : ptr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= '0;
    else ptr_q <= ptr_d;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_sel_q <= '0;
    end else if (load_en) begin
      out_valid_q <= found;
      if (found) begin
        out_data_q <= win_data;
        out_sel_q <= win;
      end
    end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_sel = out_sel_q;
endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux: directed vector table, reset corner cases, and randomized traffic against a queue-free reference model.
module tb_rr_stream_mux;
  localparam int N = 4;
  localparam int W = 8;
  localparam logic [31:0] D = 32'h13121110;
  localparam logic [31:0] A = 32'h00A50000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] in_valid = '0;
  logic [N-1:0] in_ready;
  logic [N*W-1:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [1:0] out_sel;
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic        ordy;
    logic [3:0]  rdy;
    logic        ov;
    logic [7:0]  od;
    logic [1:0]  sel;
  } vec_t;

  always #5 clk = ~clk;

  rr_stream_mux #(.N_CH(N), .DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel), .out_ready(out_ready)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic [3:0] rdy, input logic ov, input logic [7:0] od, input logic [1:0] sel);
    chk({nm, ".in_ready"}, 32'(in_ready), 32'(rdy));
    chk({nm, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({nm, ".out_data"}, 32'(out_data), 32'(od));
    chk({nm, ".out_sel"}, 32'(out_sel), 32'(sel));
  endtask

  vec_t tbl[17];
  int mptr, win;
  logic mov, load;
  logic [7:0] mod;
  logic [1:0] msel;
  logic [3:0] erdy;

  initial begin
    tbl[0]  = '{4'b0100, A, 1'b1, 4'b0100, 1'b0, 8'h00, 2'd0};
    tbl[1]  = '{4'b1111, D, 1'b1, 4'b1000, 1'b1, 8'hA5, 2'd2};
    tbl[2]  = '{4'b1111, D, 1'b1, 4'b0001, 1'b1, 8'h13, 2'd3};
    tbl[3]  = '{4'b1111, D, 1'b1, 4'b0010, 1'b1, 8'h10, 2'd0};
    tbl[4]  = '{4'b1111, D, 1'b1, 4'b0100, 1'b1, 8'h11, 2'd1};
    tbl[5]  = '{4'b1111, D, 1'b1, 4'b1000, 1'b1, 8'h12, 2'd2};
    tbl[6]  = '{4'b1111, D, 1'b1, 4'b0001, 1'b1, 8'h13, 2'd3};
    tbl[7]  = '{4'b1111, D, 1'b1, 4'b0010, 1'b1, 8'h10, 2'd0};
    tbl[8]  = '{4'b1111, D, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
    tbl[9]  = '{4'b1111, D, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
    tbl[10] = '{4'b1111, D, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
    tbl[11] = '{4'b1111, D, 1'b1, 4'b0100, 1'b1, 8'h11, 2'd1};
    tbl[12] = '{4'b1111, D, 1'b1, 4'b1000, 1'b1, 8'h12, 2'd2};
    tbl[13] = '{4'b0000, D, 1'b1, 4'b0000, 1'b1, 8'h13, 2'd3};
    tbl[14] = '{4'b0000, D, 1'b1, 4'b0000, 1'b0, 8'h13, 2'd3};
    tbl[15] = '{4'b1001, D, 1'b1, 4'b0001, 1'b0, 8'h13, 2'd3};
    tbl[16] = '{4'b0000, D, 1'b1, 4'b0000, 1'b1, 8'h10, 2'd0};

    // Reset held with every channel requesting and the consumer ready.
    rst_n = 1'b0;
    in_valid = '1;
    in_data = D;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_all($sformatf("reset%0d", i), 4'b0000, 1'b0, 8'h00, 2'd0);
      cyc();
    end
    rst_n = 1'b1;

`ifndef RR_MUX_FIXED_PRIO_EN
    for (int i = 0; i < 17; i++) begin
      in_valid = tbl[i].v;
      in_data = tbl[i].d;
      out_ready = tbl[i].ordy;
      #1;
      chk_all($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].ov, tbl[i].od, tbl[i].sel);
      cyc();
    end
`else
    for (int i = 0; i < 6; i++) begin
      in_valid = '1;
      in_data = D;
      out_ready = 1'b1;
      #1;
      chk($sformatf("fixed_rdy%0d", i), 32'(in_ready), 32'h1);
      cyc();
      chk($sformatf("fixed_sel%0d", i), 32'(out_sel), 32'd0);
      chk($sformatf("fixed_data%0d", i), 32'(out_data), 32'h10);
    end
`endif

    // Asynchronous reset between edges during full load.
    in_valid = '1;
    in_data = D;
    out_ready = 1'b1;
    cyc();
    cyc();
    cyc();
    chk("mid_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_async_valid", 32'(out_valid), 32'd0);
    chk("mid_async_rdy", 32'(in_ready), 32'd0);
    cyc();
    rst_n = 1'b1;
    #1;
    chk("mid_rel_rdy", 32'(in_ready), 32'h1);
    cyc();
    chk("mid_rel_valid", 32'(out_valid), 32'd1);
    chk("mid_rel_sel", 32'(out_sel), 32'd0);
    chk("mid_rel_data", 32'(out_data), 32'h10);

    // Randomized traffic against a reference model.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    mptr = 0;
    mov = 1'b0;
    mod = 8'h00;
    msel = 2'd0;
    for (int c = 0; c < 400; c++) begin
      in_valid = 4'($urandom);
      in_data = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      load = !mov || out_ready;
      win = -1;
      for (int i = 0; i < N; i++)
        if (win < 0 && in_valid[(mptr + i) % N]) win = (mptr + i) % N;
      erdy = (load && win >= 0) ? 4'(1 << win) : 4'b0000;
      chk_all($sformatf("rand%0d", c), erdy, mov, mod, msel);
      cyc();
      if (load) begin
        if (win >= 0) begin
          mov = 1'b1;
          mod = in_data[win*W +: W];
          msel = 2'(win);
`ifndef RR_MUX_FIXED_PRIO_EN
          mptr = (win + 1) % N;
`endif
        end else mov = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- N-to-1 valid/ready stream multiplexer. It is the merging counterpart to the team's demux blocks: N producer channels share one consumer.
- Round-robin arbitration selects the channel each cycle.
- One registered output stage, tagged with the source channel index.
- Throughput: one word per clock.

Parameters:
- N_CH, 4, number of input channels (2..16; non-power-of-two allowed)
- DATA_W, 8, data width per channel
- SEL_W is a derived localparam, not overridable: $clog2(N_CH), minimum 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  N_CH  per-channel valid; bit i belongs to channel i
- in_data  input  N_CH*DATA_W  packed data; channel i occupies bits [i*DATA_W +: DATA_W]
- in_ready  output  N_CH  per-channel accept strobe; combinational
- out_valid  output  1  output register holds a word
- out_data  output  DATA_W  registered data
- out_sel  output  SEL_W  registered index of the channel that supplied out_data
- out_ready  input  1  consumer accepts the word

Behaviour:
- Reset is asynchronous, active-low, one clock domain. Reset values:
  - out_valid=0, out_data=0, out_sel=0
  - round-robin pointer ptr=0
  - in_ready=0 while rst_n=0
- A transfer occurs on a channel when valid and ready are both high at a rising edge.
- load_en = !out_valid || out_ready. The output register may accept a new word this cycle.
- Arbitration (combinational):
  - Search in_valid starting at ptr, ascending with wrap N_CH-1 -> 0.
  - The first set bit is the winner; grant is one-hot.
  - No bits set -> no grant.
- in_ready[i] = load_en && grant[i]. At most one in_ready bit is high per cycle.
  - in_ready never depends on in_valid of the same channel except through arbitration.
  - It may depend combinationally on out_ready.
- On an edge with load_en=1 and a grant:
  - out_data <= winner's data, out_sel <= winner index, out_valid <= 1.
  - ptr <= winner+1, wrapping to 0 after N_CH-1.
- On an edge with load_en=1 and no grant:
  - out_valid <= 0; out_data/out_sel hold their old values.
  - ptr unchanged.
- On an edge with load_en=0 (out_valid=1, out_ready=0):
  - out_valid, out_data and out_sel hold.
  - All in_ready=0; ptr unchanged.
- Latency: a word accepted at edge k appears on out_* after edge k. It can be consumed at edge k+1.
- Simultaneous drain and load: with out_valid=1 and out_ready=1, the current word leaves and the next grant loads at the same edge. There is no bubble.
- Fairness:
  - Continuously valid channels are served in cyclic order.
  - A channel waits at most N_CH-1 grants, assuming out_ready is eventually high.
- Input rule: a producer must hold in_data stable while in_valid=1 and the word has not been accepted. The block does not check this.
- Reset mid-operation:
  - Any held word is discarded; out_valid falls asynchronously.
  - After rst_n rises, arbitration restarts from channel 0.

Optional Feature:
- Macro: RR_MUX_FIXED_PRIO_EN.
- Defined:
  - Arbitration is fixed priority; the lowest-index valid channel wins.
  - ptr register is removed; the search always starts at 0.
  - Higher channels can starve.
- Undefined: round-robin as specified above.
- All ports, latency and handshake rules are identical in both builds.

Test Plan:
All scenarios use N_CH=4, DATA_W=8.
1. Reset: hold rst_n=0 with all in_valid=1111 and out_ready=1.
   - Required: out_valid=0, out_data=0x00, out_sel=0, in_ready=0000 throughout.
2. Single source: only in_valid[2]=1, data 0xA5, out_ready=1.
   - Required: in_ready=0100 in the accept cycle.
   - Next cycle: out_valid=1, out_data=0xA5, out_sel=2.
   - Next grant starts its search at ch3.
3. Full load with wrap: in_valid=1111, channel i data=0x10+i, out_ready=1 continuously.
   - Required: out_sel sequence 0,1,2,3,0,1 on consecutive cycles, with out_data 0x10,0x11,0x12,0x13,0x10,...
   - No bubbles.
4. Backpressure: the word from ch1 (0x11) is held while out_ready=0 for 3 cycles with in_valid=1111.
   - Required: out_data=0x11 and out_sel=1 stable, in_ready=0000.
   - Raise out_ready: in the same cycle in_ready=0100; next word out_sel=2.
5. Idle gap: all in_valid drop after a grant to ch3, out_ready=1.
   - Required: out_valid falls one cycle later.
   - When ch0 and ch3 are both then raised, ch0 wins because ptr=0.
6. Async reset mid-stream: pull rst_n low between edges during scenario 3.
   - Required: out_valid=0 immediately, with no clock edge.
   - After release with in_valid=1111: first out_sel=0.
   - With RR_MUX_FIXED_PRIO_EN defined and scenario 3 stimulus: out_sel=0 every cycle.
